// File: rtl/l_func_feeder.sv
// Operand feeder for the Paillier L-function divider: streams in x and n, forms x-1
// with a block-serial borrow chain, buffers the result and bursts it to the divider.
module l_func_feeder #(
  parameter int N     = 4096,
  parameter int M     = 2048,
  parameter int BLOCK = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [BLOCK-1:0] x_in_i,
  input  logic [BLOCK-1:0] n_in_i,
  input  logic             div_idle_i,
  output logic             div_start_o,
  output logic             div_dvld_o,
  output logic [BLOCK-1:0] div_x_o,
  output logic [BLOCK-1:0] div_y_o,
  output logic             busy_o,
  output logic             underflow_o
);

  localparam int NCNT = N / BLOCK;
  localparam int MCNT = M / BLOCK;
  localparam int XW   = $clog2(NCNT);
  localparam int YW   = $clog2(MCNT);
  localparam logic [5:0] LAST_BEAT = 6'(NCNT - 1);
  localparam logic [5:0] MCNT6     = 6'(MCNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_SEND  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             underflow_q, underflow_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             dvld_q, dvld_d;
  logic [BLOCK-1:0] div_x_q, div_x_d;
  logic [BLOCK-1:0] div_y_q, div_y_d;

  logic [BLOCK-1:0] xb_q [NCNT];
  logic [BLOCK-1:0] nb_q [MCNT];

  logic             hs_s;
  logic             borrow_in_s;
  logic             borrow_out_s;
  logic [BLOCK-1:0] wr_x_s;
  logic             wr_en_s;
  logic             wr_nb_s;

  assign hs_s         = in_valid_i & in_ready_q;
  // Beat 0 always starts the chain with a borrow of one, i.e. subtracts the 1.
  assign borrow_in_s  = (state_q == S_IDLE) ? 1'b1 : borrow_q;
  assign wr_x_s       = x_in_i - {{(BLOCK-1){1'b0}}, borrow_in_s};
  assign borrow_out_s = borrow_in_s & (x_in_i == {BLOCK{1'b0}});
  assign wr_nb_s      = wr_en_s & (cnt_q < MCNT6);

  // Next-state, counter, borrow chain and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    underflow_d = underflow_q;
    wr_en_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d    = 6'd0;
        borrow_d = 1'b1;
        if (hs_s) begin
          wr_en_s     = 1'b1;
          underflow_d = 1'b0;
          borrow_d    = borrow_out_s;
          cnt_d       = 6'd1;
          state_d     = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (hs_s) begin
          wr_en_s  = 1'b1;
          borrow_d = borrow_out_s;
          if (cnt_q == LAST_BEAT) begin
            underflow_d = borrow_out_s;
            cnt_d       = 6'd0;
            state_d     = S_WAIT;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WAIT: begin
        if (div_idle_i) begin
          state_d = S_START;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_START: begin
        cnt_d   = 6'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        cnt_d   = 6'd0;
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
    start_d    = (state_d == S_START);
    dvld_d     = (state_d == S_SEND);
    div_x_d    = div_x_q;
    div_y_d    = div_y_q;
    // Output data is indexed by the beat that will be on the bus next cycle.
    if (dvld_d) begin
      div_x_d = xb_q[cnt_d[XW-1:0]];
      if (cnt_d < MCNT6) begin
        div_y_d = nb_q[cnt_d[YW-1:0]];
      end else begin
        div_y_d = {BLOCK{1'b0}};
      end
    end else begin
      div_x_d = div_x_q;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      borrow_q    <= 1'b1;
      underflow_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      dvld_q      <= 1'b0;
      div_x_q     <= {BLOCK{1'b0}};
      div_y_q     <= {BLOCK{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      underflow_q <= underflow_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      dvld_q      <= dvld_d;
      div_x_q     <= div_x_d;
      div_y_q     <= div_y_d;
    end
  end

  // Operand buffers; contents are only read after a complete load
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      xb_q[cnt_q[XW-1:0]] <= wr_x_s;
    end
    if (wr_nb_s) begin
      nb_q[cnt_q[YW-1:0]] <= n_in_i;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign div_start_o = start_q;
  assign div_dvld_o  = dvld_q;
  assign div_x_o     = div_x_q;
  assign div_y_o     = div_y_q;
  assign underflow_o = underflow_q;

endmodule
